mul_div_unit: RTL and testbench

// - Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
// - Executes mult/multu/div/divu/mthi/mtlo from rs/rt operands; hi/lo feed the GRF write-data mux for mfhi/mflo.
// - busy tells the controller to stall any further HI/LO instruction until the result is committed.

---
 rtl/mul_div_unit.sv | 133 +++++++++++++
 tb/tb_mul_div_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair; busy stalls further HI/LO ops.
// Optional trace of HI/LO writes is compiled in when MD_TRACE_EN is defined.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] pc_now_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [63:0]   res_q, res_d;
  logic          nocommit_q;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q;

  logic signed [63:0] smul;
  logic [63:0]        umul;
  logic [31:0]        sq, sr, uq, ur;
  logic               div0, ovf;

  assign smul = $signed(a_i) * $signed(b_i);
  assign umul = {32'd0, a_i} * {32'd0, b_i};
  assign div0 = (b_i == 32'd0);
  assign ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  // Divide-by-zero never commits, so its quotient is a don't-care; the one signed overflow case is pinned.
  always_comb begin
    sq = '0;
    sr = '0;
    uq = '0;
    ur = '0;
    if (!div0) begin
      uq = a_i / b_i;
      ur = a_i % b_i;
      if (ovf) begin
        sq = a_i;
        sr = '0;
      end else begin
        sq = $signed(a_i) / $signed(b_i);
        sr = $signed(a_i) % $signed(b_i);
      end
    end
  end

  always_comb begin
    res_d = '0;
    case (op_i[1:0])
      2'b00:   res_d = smul;
      2'b01:   res_d = umul;
      2'b10:   res_d = {sr, sq};
      default: res_d = {ur, uq};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      res_q      <= '0;
      nocommit_q <= 1'b0;
      busy_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !op_i[2]) begin
            res_q      <= res_d;
            nocommit_q <= op_i[1] & div0;
            cnt_q      <= op_i[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            busy_q     <= 1'b1;
            state_q    <= BUSY;
          end else if (start_i && !op_i[1]) begin
            if (op_i[0]) lo_q <= a_i;
            else         hi_q <= a_i;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (!nocommit_q) begin
              hi_q <= res_q[63:32];
              lo_q <= res_q[31:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

`ifdef MD_TRACE_EN
  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      pc_q <= pc_now_i;
      if (op_i == 3'b100) $display("@%h: $hi <= %h", pc_now_i, a_i);
      if (op_i == 3'b101) $display("@%h: $lo <= %h", pc_now_i, a_i);
    end else if (state_q == BUSY && cnt_q == CW'(1) && !nocommit_q) begin
      if (res_q[63:32] != hi_q) $display("@%h: $hi <= %h", pc_q, res_q[63:32]);
      if (res_q[31:0]  != lo_q) $display("@%h: $lo <= %h", pc_q, res_q[31:0]);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc_now_i;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: drives and samples on the falling edge, checks against hand-computed values.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i, pc_now_i;
  logic        busy_o;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .pc_now_i (pc_now_i),
    .busy_o   (busy_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a falling edge; holds start for exactly one rising edge, returns at the next falling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i  = 1'b1;
    op_i     = op;
    a_i      = a;
    b_i      = b;
    pc_now_i = pc_now_i + 32'd4;
    @(negedge clk);
    start_i  = 1'b0;
  endtask

  // Expects n busy cycles with HI/LO held at old values; optionally fires an mtlo mid-flight.
  task automatic run_busy(input string tag, input int n, input logic [31:0] old_hi,
                          input logic [31:0] old_lo, input bit inject);
    for (int i = 0; i < n; i++) begin
      check({tag, " busy"}, {31'd0, busy_o}, 32'd1);
      if (i == 0 || i == n - 1) begin
        check({tag, " hold hi"}, hi_o, old_hi);
        check({tag, " hold lo"}, lo_o, old_lo);
      end
      if (inject && i == 1) begin
        start_i = 1'b1;
        op_i    = 3'b101;
        a_i     = 32'h0000_ABCD;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    check({tag, " done"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start_i  = 1'b0;
    op_i     = 3'b000;
    a_i      = '0;
    b_i      = '0;
    pc_now_i = 32'h0040_0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset hi", hi_o, 32'd0);
    check("reset lo", lo_o, 32'd0);

    issue(3'b000, 32'hFFFF_FFFD, 32'd5);
    run_busy("mult", 5, 32'd0, 32'd0, 1'b0);
    check("mult hi", hi_o, 32'hFFFF_FFFF);
    check("mult lo", lo_o, 32'hFFFF_FFF1);

    issue(3'b001, 32'hFFFF_FFFF, 32'd2);
    run_busy("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    check("multu hi", hi_o, 32'h0000_0001);
    check("multu lo", lo_o, 32'hFFFF_FFFE);

    // Back-to-back: issued in the first idle cycle after commit.
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    run_busy("div", 10, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    check("div hi", hi_o, 32'hFFFF_FFFF);
    check("div lo", lo_o, 32'hFFFF_FFFD);

    issue(3'b011, 32'hFFFF_FFF9, 32'd2);
    run_busy("divu", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    check("divu hi", hi_o, 32'h0000_0001);
    check("divu lo", lo_o, 32'h7FFF_FFFC);

    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_busy("div ovf", 10, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    check("div ovf hi", hi_o, 32'h0000_0000);
    check("div ovf lo", lo_o, 32'h8000_0000);

    issue(3'b100, 32'h0000_0011, 32'd0);
    check("mthi busy", {31'd0, busy_o}, 32'd0);
    check("mthi hi", hi_o, 32'h0000_0011);
    issue(3'b101, 32'h0000_0022, 32'd0);
    check("mtlo busy", {31'd0, busy_o}, 32'd0);
    check("mtlo lo", lo_o, 32'h0000_0022);
    check("mtlo hi kept", hi_o, 32'h0000_0011);

    issue(3'b011, 32'd7, 32'd0);
    run_busy("divz", 10, 32'h0000_0011, 32'h0000_0022, 1'b0);
    check("divz hi", hi_o, 32'h0000_0011);
    check("divz lo", lo_o, 32'h0000_0022);

    issue(3'b110, 32'h1234_5678, 32'd3);
    check("nop busy", {31'd0, busy_o}, 32'd0);
    check("nop hi", hi_o, 32'h0000_0011);
    check("nop lo", lo_o, 32'h0000_0022);

    issue(3'b000, 32'd3, 32'd4);
    run_busy("mult+mtlo", 5, 32'h0000_0011, 32'h0000_0022, 1'b1);
    check("ignored mtlo hi", hi_o, 32'h0000_0000);
    check("ignored mtlo lo", lo_o, 32'h0000_000C);
    issue(3'b101, 32'h0000_ABCD, 32'd0);
    check("idle mtlo lo", lo_o, 32'h0000_ABCD);
    check("idle mtlo busy", {31'd0, busy_o}, 32'd0);

    issue(3'b010, 32'd100, 32'd7);
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("pre-reset busy", {31'd0, busy_o}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid reset busy", {31'd0, busy_o}, 32'd0);
    check("mid reset hi", hi_o, 32'd0);
    check("mid reset lo", lo_o, 32'd0);
    repeat (12) @(negedge clk);
    check("no late commit busy", {31'd0, busy_o}, 32'd0);
    check("no late commit hi", hi_o, 32'd0);
    check("no late commit lo", lo_o, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
